niosii_system_sysid_ext: RTL and testbench
==========================================

# niosII_system_sysid_ext

Parametrised successor to the system ID peripheral. It is an Avalon-MM slave on the Nios II data master that returns the system ID and build timestamp, and adds:
- a free-running 64-bit uptime counter with coherent high-word snapshot;
- a byte-writable scratch register;
- a capability word;
- NUM_USER read-only status channels.

Reads are registered with fixed latency 1 and signalled by readdatavalid.

## Interface
- ID_VALUE, 32'h0000_0000, system ID returned at word 0
- TIMESTAMP, 32'd1394830679, build timestamp returned at word 1
- NUM_USER, 4, number of 32-bit user status channels (0..8)
- ADDR_W, 4, word-address width; 8+NUM_USER <= 2**ADDR_W
- SCRATCH_INIT, 32'h0000_0000, scratch register reset value
- clock  in  1  system clock, all logic rising-edge
- reset  in  1  asynchronous, active-high reset
- address  in  ADDR_W  word address
- read  in  1  read strobe, one cycle per access
- write  in  1  write strobe, one cycle per access
- writedata  in  32  write data
- byteenable  in  4  byte lanes for write; bit n covers writedata[8n+7:8n]
- user_in  in  32*NUM_USER  status channels, channel k at bits [32k+31:32k]
- readdata  out  32  registered read data
- readdatavalid  out  1  high one cycle when readdata is valid

## Operation
Register map (word addresses):
- 0 ID: RO, ID_VALUE.
- 1 TIMESTAMP: RO, TIMESTAMP.
- 2 UPTIME_LO: RO, cnt[31:0]. A read also captures cnt[63:32] into hi_snap in the same cycle.
- 3 UPTIME_HI: RO, returns hi_snap, not the live counter.
- 4 SCRATCH: RW, byte-lane writes per byteenable.
- 5 CTRL:
  - bit0 CLEAR: write 1 zeroes cnt; self-clearing, always reads 0.
  - bit1 FREEZE: RW, stops cnt increments while 1.
  - Other bits read 0.
  - byteenable[0] must be set for a CTRL write to take effect.
- 6 CAPS: RO, {16'h0002 version, 4'b0, ADDR_W[3:0], NUM_USER[7:0]}.
- 7: reads 0.
- 8..8+NUM_USER-1 USERk: RO, user_in channel k sampled in the read cycle.
- All other addresses read 0. Writes to RO or unmapped addresses are ignored and raise no error.

Uptime counter:
- cnt is 64-bit and increments by 1 every clock while FREEZE=0.
- Wraps from 2^64-1 to 0.
- A CLEAR write sets cnt to 0 on the next edge. CLEAR has priority over increment and applies even when FREEZE=1.

## Timing
- Read accepted in cycle N (read=1). readdata and readdatavalid=1 are presented in cycle N+1. No waitrequest.
- Back-to-back reads every cycle are allowed and give one valid result per cycle.
- readdata holds its last value when readdatavalid=0.
- Writes take effect at the edge ending the write cycle and are visible to a read issued in the next cycle.
- UPTIME_LO read in cycle N returns cnt as held during cycle N. hi_snap then equals the matching cnt[63:32]. LO followed by HI is therefore a coherent 64-bit value.
- read and write together (same or different address): the write is performed and the read returns the pre-write value. A same-cycle CLEAR with an UPTIME_LO read returns the pre-clear count.
- Reset (async assert, sync release):
  - readdata=0, readdatavalid=0;
  - cnt=0, hi_snap=0;
  - SCRATCH=SCRATCH_INIT, FREEZE=0.
- Reset asserted mid-read: readdatavalid drops immediately and that read produces no response.

## Test plan
- Reset, then read address 0 and address 1 in consecutive cycles -> readdatavalid high in the two following cycles with ID_VALUE then 1394830679. CAPS read -> 32'h0002_0404 at defaults.
- Write SCRATCH 32'hDEADBEEF with be=4'hF, then 32'h00000011 with be=4'b0001, then read -> 32'hDEADBE11. After a reset pulse, the read returns SCRATCH_INIT.
- Force cnt to 64'h0000_0001_FFFF_FFFF via CLEAR plus a known number of cycles or a bench preload, read UPTIME_LO just before the rollover, then UPTIME_HI -> the HI word matches the LO sample and not the post-carry value.
- Write CTRL=2 (FREEZE), read UPTIME_LO twice 10 cycles apart -> identical values. Then write CTRL=3 -> the next read returns 0 or a small count that stays constant. Then write CTRL=0 -> count resumes incrementing by 1 per cycle.
- Drive user_in channel 2 = 32'hA5A5_0003, read address 10 -> 32'hA5A5_0003. Read addresses 7, 12 and 15 -> 0.
- Read and write to SCRATCH in the same cycle with old value 1 and writedata 2 -> readdata=1, and the next read returns 2. Assert reset in the cycle after a read -> readdatavalid=0 immediately.

Source files
------------

// File: rtl/niosii_system_sysid_ext.sv
// System ID peripheral with uptime counter, scratch register, capability word
// and read-only user status channels. Avalon-MM slave, fixed read latency 1.
module niosii_system_sysid_ext #(
  parameter logic [31:0] ID_VALUE     = 32'h0000_0000,
  parameter logic [31:0] TIMESTAMP    = 32'd1394830679,
  parameter int unsigned NUM_USER     = 4,
  parameter int unsigned ADDR_W       = 4,
  parameter logic [31:0] SCRATCH_INIT = 32'h0000_0000,
  // Keep the user bus at least one channel wide so NUM_USER=0 stays legal
  localparam int unsigned UserW       = (NUM_USER > 0) ? 32 * NUM_USER : 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic              read,
  input  logic              write,
  input  logic [31:0]       writedata,
  input  logic [3:0]        byteenable,
  input  logic [UserW-1:0]  user_in,
  output logic [31:0]       readdata,
  output logic              readdatavalid
);

  localparam logic [31:0] AddrWVec   = 32'(ADDR_W);
  localparam logic [31:0] NumUserVec = 32'(NUM_USER);
  localparam logic [31:0] Caps       = {16'h0002, 4'b0000, AddrWVec[3:0], NumUserVec[7:0]};

  logic [63:0] cnt_q, cnt_d;
  logic [31:0] hi_snap_q, hi_snap_d;
  logic [31:0] scratch_q, scratch_d;
  logic        freeze_q, freeze_d;
  logic [31:0] readdata_q, readdata_d;
  logic        rvalid_q, rvalid_d;

  logic [31:0] addr_ext;
  logic [31:0] rdata_mux;
  logic        wr_scratch, wr_ctrl, rd_lo;

  assign addr_ext   = 32'(address);
  assign wr_scratch = write && (addr_ext == 32'd4);
  assign wr_ctrl    = write && (addr_ext == 32'd5) && byteenable[0];
  assign rd_lo      = read && (addr_ext == 32'd2);

  // Read data mux; everything reflects pre-write state of the current cycle
  always_comb begin
    rdata_mux = '0;
    case (addr_ext)
      32'd0:   rdata_mux = ID_VALUE;
      32'd1:   rdata_mux = TIMESTAMP;
      32'd2:   rdata_mux = cnt_q[31:0];
      32'd3:   rdata_mux = hi_snap_q;
      32'd4:   rdata_mux = scratch_q;
      32'd5:   rdata_mux = {30'b0, freeze_q, 1'b0};
      32'd6:   rdata_mux = Caps;
      default: begin
        for (int k = 0; k < int'(NUM_USER); k++) begin
          if (addr_ext == 32'(8 + k)) rdata_mux = user_in[32*k +: 32];
        end
      end
    endcase
  end

  // Next-state for counter, snapshot, scratch, control and read response
  always_comb begin
    scratch_d = scratch_q;
    for (int b = 0; b < 4; b++) begin
      if (wr_scratch && byteenable[b]) scratch_d[8*b +: 8] = writedata[8*b +: 8];
    end

    freeze_d = wr_ctrl ? writedata[1] : freeze_q;

    // CLEAR wins over increment and ignores FREEZE
    cnt_d = cnt_q;
    if (wr_ctrl && writedata[0]) begin
      cnt_d = '0;
    end else if (!freeze_q) begin
      cnt_d = cnt_q + 64'd1;
    end

    // Snapshot the high word alongside a low-word read so LO then HI is coherent
    hi_snap_d = rd_lo ? cnt_q[63:32] : hi_snap_q;

    readdata_d = read ? rdata_mux : readdata_q;
    rvalid_d   = read;
  end

  // State registers; async reset also kills any read response in flight
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q      <= '0;
      hi_snap_q  <= '0;
      scratch_q  <= SCRATCH_INIT;
      freeze_q   <= 1'b0;
      readdata_q <= '0;
      rvalid_q   <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      hi_snap_q  <= hi_snap_d;
      scratch_q  <= scratch_d;
      freeze_q   <= freeze_d;
      readdata_q <= readdata_d;
      rvalid_q   <= rvalid_d;
    end
  end

  assign readdata      = readdata_q;
  assign readdatavalid = rvalid_q;

endmodule

// File: tb/tb_niosii_system_sysid_ext.sv
// Scoreboard bench for niosii_system_sysid_ext at default parameters.
module tb_niosii_system_sysid_ext;

  localparam int unsigned NumUser = 4;
  localparam int unsigned AddrW   = 4;

  logic                 clock = 1'b0;
  logic                 reset = 1'b1;
  logic [AddrW-1:0]     address = '0;
  logic                 read = 1'b0;
  logic                 write = 1'b0;
  logic [31:0]          writedata = '0;
  logic [3:0]           byteenable = '0;
  logic [32*NumUser-1:0] user_in;
  logic [31:0]          readdata;
  logic                 readdatavalid;

  niosii_system_sysid_ext dut (
    .clock         (clock),
    .reset         (reset),
    .address       (address),
    .read          (read),
    .write         (write),
    .writedata     (writedata),
    .byteenable    (byteenable),
    .user_in       (user_in),
    .readdata      (readdata),
    .readdatavalid (readdatavalid)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] data;
    int unsigned due;
    string       tag;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_errors = 0;

  // Spec-level model of the stateful registers
  logic [63:0] m_cnt;
  logic [31:0] m_hi;
  logic [31:0] m_scratch;
  logic        m_freeze;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Response monitor: each expected read must be answered exactly one cycle later
  always @(negedge clock) begin
    if (sb.size() > 0 && sb[0].due == cyc) begin
      check({sb[0].tag, "_valid"}, 32'(readdatavalid), 32'd1);
      check(sb[0].tag, readdata, sb[0].data);
      void'(sb.pop_front());
    end else if (readdatavalid) begin
      check("spurious_valid", 32'(readdatavalid), 32'd0);
    end
  end

  function automatic logic [31:0] model_read(input logic [AddrW-1:0] a);
    case (a)
      4'd2:    return m_cnt[31:0];
      4'd3:    return m_hi;
      4'd4:    return m_scratch;
      4'd5:    return {30'b0, m_freeze, 1'b0};
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    m_cnt = '0; m_hi = '0; m_scratch = 32'h0; m_freeze = 1'b0;
  endtask

  task automatic model_edge(input logic rd, input logic wr, input logic [AddrW-1:0] a,
                            input logic [31:0] wd, input logic [3:0] be);
    logic ctrl;
    ctrl = wr && a == 4'd5 && be[0];
    if (rd && a == 4'd2) m_hi = m_cnt[63:32];
    if (ctrl && wd[0]) m_cnt = '0;
    else if (!m_freeze) m_cnt = m_cnt + 64'd1;
    if (ctrl) m_freeze = wd[1];
    if (wr && a == 4'd4)
      for (int b = 0; b < 4; b++) if (be[b]) m_scratch[8*b +: 8] = wd[8*b +: 8];
  endtask

  // One bus cycle, starting and ending at a negedge
  task automatic bus(input logic rd, input logic wr, input logic [AddrW-1:0] a,
                     input logic [31:0] wd, input logic [3:0] be,
                     input logic use_model, input logic [31:0] lit, input string tag);
    read = rd; write = wr; address = a; writedata = wd; byteenable = be;
    if (rd) sb.push_back('{use_model ? model_read(a) : lit, cyc + 1, tag});
    @(posedge clock);
    model_edge(rd, wr, a, wd, be);
    @(negedge clock);
    read = 1'b0; write = 1'b0;
  endtask

  task automatic rd_lit(input logic [AddrW-1:0] a, input logic [31:0] v, input string tag);
    bus(1'b1, 1'b0, a, 32'h0, 4'h0, 1'b0, v, tag);
  endtask

  task automatic rd_model(input logic [AddrW-1:0] a, input string tag);
    bus(1'b1, 1'b0, a, 32'h0, 4'h0, 1'b1, 32'h0, tag);
  endtask

  task automatic wr(input logic [AddrW-1:0] a, input logic [31:0] wd, input logic [3:0] be);
    bus(1'b0, 1'b1, a, wd, be, 1'b0, 32'h0, "");
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) bus(1'b0, 1'b0, '0, 32'h0, 4'h0, 1'b0, 32'h0, "");
  endtask

  initial begin
    user_in = {32'h3333_0003, 32'hA5A5_0003, 32'h1111_0001, 32'h0C0C_0000};
    model_reset();
    repeat (2) @(negedge clock);
    check("rst_valid", 32'(readdatavalid), 32'd0);
    check("rst_readdata", readdata, 32'd0);
    reset = 1'b0;

    // ID and timestamp back to back, then capability word
    rd_lit(4'd0, 32'h0000_0000, "id");
    rd_lit(4'd1, 32'd1394830679, "timestamp");
    rd_lit(4'd6, 32'h0002_0404, "caps");

    // Scratch byte lanes
    wr(4'd4, 32'hDEAD_BEEF, 4'hF);
    wr(4'd4, 32'h0000_0011, 4'b0001);
    rd_lit(4'd4, 32'hDEAD_BE11, "scratch_bytes");

    // Freeze, lane-gated CTRL, clear under freeze, resume
    wr(4'd5, 32'd2, 4'h1);
    rd_model(4'd2, "frz_a");
    idle(10);
    rd_model(4'd2, "frz_b");
    wr(4'd5, 32'd0, 4'b1110);
    rd_lit(4'd5, 32'd2, "ctrl_be0_gate");
    wr(4'd5, 32'd3, 4'h1);
    rd_lit(4'd2, 32'd0, "clr_frz_a");
    idle(3);
    rd_lit(4'd2, 32'd0, "clr_frz_b");
    rd_lit(4'd5, 32'd2, "ctrl_readback");
    wr(4'd5, 32'd0, 4'h1);
    rd_lit(4'd2, 32'd0, "resume_0");
    rd_lit(4'd2, 32'd1, "resume_1");
    rd_lit(4'd2, 32'd2, "resume_2");

    // Coherent snapshot across a low-word carry
    force dut.cnt_q = 64'h0000_0001_FFFF_FFFD;
    m_cnt = 64'h0000_0001_FFFF_FFFD;
    #1 release dut.cnt_q;
    rd_lit(4'd2, 32'hFFFF_FFFD, "lo_pre_carry");
    idle(4);
    rd_lit(4'd3, 32'h0000_0001, "hi_snap");
    rd_model(4'd2, "lo_post_carry");

    // Full 64-bit wrap
    force dut.cnt_q = 64'hFFFF_FFFF_FFFF_FFFF;
    m_cnt = 64'hFFFF_FFFF_FFFF_FFFF;
    #1 release dut.cnt_q;
    idle(1);
    rd_lit(4'd2, 32'd0, "wrap_lo");
    rd_lit(4'd3, 32'd0, "wrap_hi");

    // User channels and unmapped space; RO writes ignored
    rd_lit(4'd10, 32'hA5A5_0003, "user2");
    rd_lit(4'd8, 32'h0C0C_0000, "user0");
    rd_lit(4'd7, 32'd0, "addr7");
    rd_lit(4'd12, 32'd0, "addr12");
    rd_lit(4'd15, 32'd0, "addr15");
    wr(4'd0, 32'hFFFF_FFFF, 4'hF);
    rd_lit(4'd0, 32'h0000_0000, "id_ro");

    // Read and write in the same cycle return the pre-write value
    wr(4'd4, 32'd1, 4'hF);
    bus(1'b1, 1'b1, 4'd4, 32'd2, 4'hF, 1'b0, 32'd1, "rw_old");
    rd_lit(4'd4, 32'd2, "rw_new");

    // Reset in the cycle after a read cancels its response
    read = 1'b1; address = 4'd4;
    @(posedge clock);
    #1 reset = 1'b1; read = 1'b0;
    #1 check("rst_mid_read_valid", 32'(readdatavalid), 32'd0);
    check("rst_mid_read_data", readdata, 32'd0);
    model_reset();
    @(negedge clock);
    reset = 1'b0;
    rd_lit(4'd4, 32'h0000_0000, "scratch_init");
    rd_lit(4'd5, 32'd0, "ctrl_after_rst");

    idle(3);
    check("sb_drain", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
